// File: rtl/req_gnt_pkg.sv
// Shared types and defaults for the request/grant responder.
package req_gnt_pkg;

    localparam int DEFAULT_DATA_W = 8;
    localparam int DEFAULT_DEPTH  = 4;

    // Responder FSM states; only GRANT drives gnt high.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        STALL = 2'd2
    } state_e;

endpackage

// File: rtl/req_gnt_fifo.sv
// Capture FIFO for the responder: power-of-two depth, pointers wrap naturally.
module req_gnt_fifo #(
    parameter  int DATA_W = 8,
    parameter  int DEPTH  = 4,
    localparam int AW     = $clog2(DEPTH),
    localparam int CW     = AW + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic [CW-1:0]     count,
    output logic              full,
    output logic              empty
);

    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic              push_ok_s;
    logic              pop_ok_s;

    assign full      = (count_q == DEPTH_C);
    assign empty     = (count_q == {CW{1'b0}});
    assign count     = count_q;
    assign rdata     = mem_q[rd_ptr_q];
    // Overflow and underflow are refused here as a second line of defence.
    assign push_ok_s = push && !full;
    assign pop_ok_s  = pop && !empty;

    // Next pointer and occupancy values for this edge's push/pop.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok_s) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_ok_s) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push_ok_s, pop_ok_s})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer and occupancy registers, cleared by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= {AW{1'b0}};
            rd_ptr_q <= {AW{1'b0}};
            count_q  <= {CW{1'b0}};
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; contents are left as-is on reset since count gates them.
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

endmodule

// File: rtl/req_gnt_responder.sv
// Request/grant responder: grants a requester while the capture FIFO has room
// and lets a consumer pop words with a registered, one-cycle-valid read port.
// Optional build macro REQ_GNT_STATS_EN adds the saturating stall_cnt output.
module req_gnt_responder
    import req_gnt_pkg::*;
#(
    parameter  int DATA_W = DEFAULT_DATA_W,
    parameter  int DEPTH  = DEFAULT_DEPTH,
    localparam int CW     = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic [DATA_W-1:0] data,
    output logic              gnt,
    input  logic              rd_en,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic [CW-1:0]     count,
    output logic              full,
    output logic              empty
`ifdef REQ_GNT_STATS_EN
    ,
    output logic [7:0]        stall_cnt
`endif
);

    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    state_e            state_q, state_d;
    logic              push_s;
    logic              pop_s;
    logic [CW-1:0]     occ_next_s;
    logic [DATA_W-1:0] fifo_rdata_s;
    logic [DATA_W-1:0] rd_data_q;
    logic              rd_valid_q;

    req_gnt_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push_s),
        .pop   (pop_s),
        .wdata (data),
        .rdata (fifo_rdata_s),
        .count (count),
        .full  (full),
        .empty (empty)
    );

    assign gnt      = (state_q == GRANT);
    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;

    // Transfer qualification and next state from the post-edge occupancy.
    always_comb begin
        push_s     = 1'b0;
        pop_s      = 1'b0;
        occ_next_s = count;
        state_d    = IDLE;
        if (rst) begin
            state_d = IDLE;
        end else begin
            push_s     = req && gnt && !full;
            pop_s      = rd_en && !empty;
            occ_next_s = count + CW'(push_s) - CW'(pop_s);
            if (!req) begin
                state_d = IDLE;
            end else if (occ_next_s < DEPTH_C) begin
                state_d = GRANT;
            end else begin
                state_d = STALL;
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Registered read port: capture the head word on a pop, pulse valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data_q  <= {DATA_W{1'b0}};
            rd_valid_q <= 1'b0;
        end else begin
            rd_valid_q <= pop_s;
            if (pop_s) begin
                rd_data_q <= fifo_rdata_s;
            end
        end
    end

`ifdef REQ_GNT_STATS_EN
    logic [7:0] stall_cnt_q;

    assign stall_cnt = stall_cnt_q;

    // Saturating count of cycles where the requester waits without a grant.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= 8'd0;
        end else if (req && !gnt && (stall_cnt_q != 8'hFF)) begin
            stall_cnt_q <= stall_cnt_q + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_req_gnt_responder.sv
// Randomized scoreboard bench for req_gnt_responder (DATA_W=8, DEPTH=4).
module tb_req_gnt_responder;

    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       req;
    logic [7:0] data;
    logic       gnt;
    logic       rd_en;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic [2:0] count;
    logic       full;
    logic       empty;
`ifdef REQ_GNT_STATS_EN
    logic [7:0] stall_cnt;
`endif

    req_gnt_responder #(.DATA_W(8), .DEPTH(DEPTH)) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .data     (data),
        .gnt      (gnt),
        .rd_en    (rd_en),
        .rd_data  (rd_data),
        .rd_valid (rd_valid),
        .count    (count),
        .full     (full),
        .empty    (empty)
`ifdef REQ_GNT_STATS_EN
        ,
        .stall_cnt(stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Expected post-edge observation for one cycle.
    typedef struct {
        bit gnt;
        int cnt;
        bit rv;
        int rd;
        int st;
    } exp_t;

    exp_t       sq[$];
    logic [7:0] mq[$];
    bit         m_gnt   = 1'b0;
    bit         m_rv    = 1'b0;
    int         m_rd    = 0;
    int         m_stall = 0;
    int         n_vec   = 0;
    int         n_err   = 0;
    bit         running = 1'b0;

    task automatic chk(input string nm, input int act, input int ex);
        n_vec++;
        if (act != ex) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, ex, $time);
        end
    endtask

    // Apply one cycle of inputs, advance the reference model, queue expectation.
    task automatic drive(input bit r, input bit q, input logic [7:0] d, input bit re);
        exp_t e;
        bit   do_push;
        rst   = r;
        req   = q;
        data  = d;
        rd_en = re;
        if (r) begin
            mq.delete();
            m_gnt   = 1'b0;
            m_rv    = 1'b0;
            m_rd    = 0;
            m_stall = 0;
        end else begin
            if (q && !m_gnt && m_stall < 255) m_stall++;
            do_push = q && m_gnt && (mq.size() < DEPTH);
            if (re && mq.size() > 0) begin
                m_rd = mq.pop_front();
                m_rv = 1'b1;
            end else begin
                m_rv = 1'b0;
            end
            if (do_push) mq.push_back(d);
            m_gnt = q && (mq.size() < DEPTH);
        end
        e.gnt = m_gnt;
        e.cnt = mq.size();
        e.rv  = m_rv;
        e.rd  = m_rd;
        e.st  = m_stall;
        sq.push_back(e);
        @(negedge clk);
    endtask

    // Monitor: after each active edge pop one expectation and compare outputs.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (sq.size() > 0) begin
            e = sq.pop_front();
            chk("gnt",      int'(gnt),      int'(e.gnt));
            chk("count",    int'(count),    e.cnt);
            chk("full",     int'(full),     int'(e.cnt == DEPTH));
            chk("empty",    int'(empty),    int'(e.cnt == 0));
            chk("rd_valid", int'(rd_valid), int'(e.rv));
            chk("rd_data",  int'(rd_data),  e.rd);
`ifdef REQ_GNT_STATS_EN
            chk("stall_cnt", int'(stall_cnt), e.st);
`endif
        end else if (running) begin
            chk("sb_underflow", 1, 0);
        end
    end

    initial begin
        logic [7:0] v;
        bit         g;
        rst = 1'b1; req = 1'b0; data = 8'h00; rd_en = 1'b0;
        running = 1'b1;
        drive(1'b1, 1'b0, 8'h00, 1'b0);
        drive(1'b1, 1'b0, 8'h00, 1'b0);
        // Grant latency with a held A5 request.
        drive(1'b0, 1'b1, 8'hA5, 1'b0);
        drive(1'b0, 1'b1, 8'hA5, 1'b0);
        // Fill to full with 01..04, then stall a few cycles.
        drive(1'b1, 1'b0, 8'h00, 1'b0);
        v = 8'h01;
        for (int i = 0; i < 9; i++) begin
            g = m_gnt;
            drive(1'b0, 1'b1, v, 1'b0);
            if (g) v = v + 8'd1;
        end
        // Pop from full, then regrant and accept 05 onward.
        drive(1'b0, 1'b1, v, 1'b1);
        for (int i = 0; i < 2; i++) begin
            g = m_gnt;
            drive(1'b0, 1'b1, v, 1'b0);
            if (g) v = v + 8'd1;
        end
        // Drain to two entries, then concurrent push/pop across wrap.
        drive(1'b0, 1'b0, 8'h00, 1'b1);
        drive(1'b0, 1'b0, 8'h00, 1'b1);
        drive(1'b0, 1'b1, v, 1'b0);
        for (int i = 0; i < 10; i++) begin
            g = m_gnt;
            drive(1'b0, 1'b1, v, 1'b1);
            if (g) v = v + 8'd1;
        end
        // Reach three entries with grant high, then reset mid-transfer.
        drive(1'b0, 1'b0, 8'h00, 1'b1);
        drive(1'b0, 1'b0, 8'h00, 1'b1);
        drive(1'b0, 1'b0, 8'h00, 1'b1);
        drive(1'b0, 1'b1, 8'h10, 1'b0);
        drive(1'b0, 1'b1, 8'h11, 1'b0);
        drive(1'b0, 1'b1, 8'h12, 1'b0);
        drive(1'b0, 1'b1, 8'h13, 1'b0);
        drive(1'b1, 1'b1, 8'h14, 1'b1);
        drive(1'b0, 1'b0, 8'h00, 1'b1);
        drive(1'b0, 1'b0, 8'h00, 1'b1);
        // Random traffic with occasional reset.
        for (int i = 0; i < 3000; i++) begin
            drive(($urandom_range(99) == 0), ($urandom_range(3) != 0),
                  8'($urandom_range(255)), ($urandom_range(1) == 1));
        end
        // Long stall to exercise saturation of the stall counter.
        drive(1'b0, 1'b0, 8'h00, 1'b0);
        for (int i = 0; i < 270; i++) begin
            drive(1'b0, 1'b1, 8'($urandom_range(255)), 1'b0);
        end
        running = 1'b0;
        chk("sb_drain", sq.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/req_gnt_responder.md
REQ_GNT_RESPONDER -- requirements
Module: req_gnt_responder

Interface
REQ-001 Parameter DATA_W, default 8, width of the request data bus.
REQ-002 Parameter DEPTH, default 4, capture-FIFO entries; power of two, 2..16.
REQ-003 Port clk, input, 1, single clock; all logic on the rising edge.
REQ-004 Port rst, input, 1, synchronous, active-high reset.
REQ-005 Port req, input, 1, requester asserts to offer data.
REQ-006 Port data, input, DATA_W, request payload; valid while req is high.
REQ-007 Port gnt, output, 1, registered grant; a transfer occurs on a rising edge with req=1 and gnt=1.
REQ-008 Port rd_en, input, 1, pop request from the consumer side.
REQ-009 Port rd_data, output, DATA_W, registered popped word.
REQ-010 Port rd_valid, output, 1, one-cycle pulse qualifying rd_data.
REQ-011 Port count, output, $clog2(DEPTH)+1, current FIFO occupancy.
REQ-012 Ports full and empty, output, 1 each, combinational from count (count==DEPTH, count==0).

Function
REQ-013 The FSM shall have three states: IDLE (gnt=0), GRANT (gnt=1) and STALL (gnt=0); gnt shall equal (state==GRANT).
REQ-014 Let occ_next be the occupancy after this edge's push and pop; next state shall be IDLE if req=0, GRANT if req=1 and occ_next<DEPTH, otherwise STALL.
REQ-015 A push (data written at the FIFO tail) shall occur only when req=1 and gnt=1 on the same edge; data is captured on that edge.
REQ-016 gnt latency: req rising with room shall give gnt=1 exactly one cycle later; a held req with room shall keep gnt high with one transfer per cycle.
REQ-017 A push that makes count==DEPTH shall drop gnt on the next cycle (STALL); no write shall ever occur when full.
REQ-018 A pop shall occur when rd_en=1 and empty=0; rd_data shall be the head word and rd_valid=1 on the following cycle. rd_en when empty is ignored (rd_valid=0, rd_data held).
REQ-019 A simultaneous push and pop shall leave count unchanged and preserve FIFO order.
REQ-020 A pop while in STALL with req held shall return the FSM to GRANT on the next cycle.
REQ-021 The read and write pointers shall wrap modulo DEPTH with no data loss.
REQ-022 If req falls while gnt=1, no transfer shall occur and the FSM shall go to IDLE.

Reset
REQ-023 When rst=1, the block shall set state=IDLE, gnt=0, count=0, pointers=0, rd_valid=0 and rd_data=0 on the next edge; FIFO contents need not be cleared.
REQ-024 A reset asserted mid-transfer or mid-stall shall discard all stored words; req/rd_en shall be ignored while rst=1.

Configuration
REQ-025 Macro REQ_GNT_STATS_EN, when defined, shall add the output stall_cnt[7:0], a saturating count of cycles with req=1 and gnt=0, which reset clears.
REQ-026 Without REQ_GNT_STATS_EN, the stall_cnt port and its logic shall be absent, with all other behaviour identical.

Structure
REQ-027 Package req_gnt_pkg shall hold the FSM state enum typedef (IDLE, GRANT, STALL) and the default DATA_W/DEPTH constants.
REQ-028 The storage shall be a sub-module req_gnt_fifo (push, pop, wdata, rdata, count, full, empty); the top level holds the FSM, the read register and the stats logic.

Verification
REQ-029 Reset, then req=1, data=8'hA5 held: gnt=0 in cycle 0 and 1 from cycle 1; after one transfer, count=1.
REQ-030 Hold req with data 8'h01..8'h04 and rd_en=0, DEPTH=4: four transfers, count=4, full=1, gnt=0 on the next cycle, and stall_cnt increments each cycle (stats build).
REQ-031 From full, pulse rd_en: rd_data=8'h01 with rd_valid=1 one cycle later, gnt returns high, and the next push accepts 8'h05.
REQ-032 Hold req and rd_en together while 2 entries are stored: count stays 2 and the output order is strictly FIFO across pointer wrap.
REQ-033 With count=3 and gnt=1, assert rst for one cycle: gnt=0, count=0, empty=1; rd_en on the next cycle gives no rd_valid.
REQ-034 Give rd_en when empty and req=0: rd_valid stays 0, the FSM stays IDLE, and stall_cnt is unchanged.
